// File: rtl/registrador_de_instrucoes.sv
// SAP-1 instruction register: latches one instruction word from the W-bus and presents
// the opcode unconditionally and the operand only while ei_lsb enables it.
module registrador_de_instrucoes #(
    parameter int DATA_W = 8,
    parameter int OPER_W = 4
) (
    input  logic              clk,
    input  logic              clr_msb,
    input  logic              load,
    input  logic              ei_lsb,
    input  logic [DATA_W-1:0] entrada_instrucao,
    output logic [DATA_W-1:0] saida_instrucao
);

    logic [DATA_W-1:0] ir_r;
    logic [OPER_W-1:0] operand_s;

    // Instruction storage; clr_msb clears asynchronously and overrides load.
    always_ff @(posedge clk or posedge clr_msb) begin
        if (clr_msb) begin
            ir_r <= {DATA_W{1'b0}};
        end else if (load) begin
            ir_r <= entrada_instrucao;
        end else begin
            ir_r <= ir_r;
        end
    end

    // Operand gate: ei_lsb only masks the visible field, never the stored word.
    always_comb begin
        operand_s = {OPER_W{1'b0}};
        if (ei_lsb) begin
            operand_s = ir_r[OPER_W-1:0];
        end else begin
            operand_s = {OPER_W{1'b0}};
        end
    end

    // Output word: opcode always visible, operand as gated above.
    always_comb begin
        saida_instrucao = {ir_r[DATA_W-1:OPER_W], operand_s};
    end

endmodule

// File: tb/tb_registrador_de_instrucoes.sv
// Randomised self-checking bench for the SAP-1 instruction register, with a
// word-level model of the stored instruction and hand-computed anchor checks.
module tb_registrador_de_instrucoes;

    logic       clk = 1'b0;
    logic       clr_msb = 1'b1;
    logic       load = 1'b0;
    logic       ei_lsb = 1'b0;
    logic [7:0] entrada_instrucao = 8'h00;
    logic [7:0] saida_instrucao;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] exp_ir = 8'h00;
    bit         chk_en = 1'b0;

    registrador_de_instrucoes #(.DATA_W(8), .OPER_W(4)) dut (
        .clk               (clk),
        .clr_msb           (clr_msb),
        .load              (load),
        .ei_lsb            (ei_lsb),
        .entrada_instrucao (entrada_instrucao),
        .saida_instrucao   (saida_instrucao)
    );

    always #5 clk = ~clk;

    // Visible word: opcode always, operand only when enabled.
    function automatic logic [7:0] model_out();
        logic [7:0] opc;
        logic [7:0] opr;
        opc = exp_ir & 8'hF0;
        opr = ei_lsb ? (exp_ir & 8'h0F) : 8'h00;
        return opc | opr;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        checks = checks + 1;
        if (act !== req) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%02h, expected 0x%02h at %0t", name, act, req, $time);
        end
    endtask

    // Drive inputs now, take one edge, then update the model; returns at posedge+2.
    task automatic step(input logic ld, input logic ei, input logic [7:0] din);
        load = ld;
        ei_lsb = ei;
        entrada_instrucao = din;
        @(posedge clk);
        #1;
        if (load && !clr_msb) exp_ir = entrada_instrucao;
        #1;
    endtask

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) check("cycle", saida_instrucao, model_out());
    end

    initial begin
        // Test 1: clear without any clock edge, both ei_lsb values.
        #1;
        check("t1_clr_ei0", saida_instrucao, 8'h00);
        ei_lsb = 1'b1;
        #1;
        check("t1_clr_ei1", saida_instrucao, 8'h00);
        @(posedge clk);
        #2;
        clr_msb = 1'b0;
        exp_ir = 8'h00;
        chk_en = 1'b1;

        // Test 2
        step(1'b1, 1'b1, 8'hB3);
        check("t2_load_b3", saida_instrucao, 8'hB3);
        ei_lsb = 1'b0;
        #1;
        check("t2_gate_b0", saida_instrucao, 8'hB0);

        // Test 3
        step(1'b1, 1'b1, 8'hF0);
        check("t3_load_f0", saida_instrucao, 8'hF0);

        // Test 4
        step(1'b1, 1'b0, 8'h0F);
        check("t4_gated_00", saida_instrucao, 8'h00);
        ei_lsb = 1'b1;
        #1;
        check("t4_open_0f", saida_instrucao, 8'h0F);

        // Test 5: mid-cycle clear with load asserted, held over edges.
        load = 1'b1;
        entrada_instrucao = 8'h0F;
        clr_msb = 1'b1;
        exp_ir = 8'h00;
        #1;
        check("t5_clr_now", saida_instrucao, 8'h00);
        step(1'b1, 1'b1, 8'h77);
        check("t5_hold1", saida_instrucao, 8'h00);
        step(1'b1, 1'b1, 8'h5C);
        check("t5_hold2", saida_instrucao, 8'h00);
        clr_msb = 1'b0;

        // Test 6: no load for several edges.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'hAA);
        check("t6_hold_00", saida_instrucao, 8'h00);

        // Randomised traffic with occasional mid-cycle clears and ei_lsb toggles.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                ei_lsb = ~ei_lsb;
                #1;
                check("rand_ei_toggle", saida_instrucao, model_out());
            end else if ($urandom_range(0, 19) == 0) begin
                load = 1'b1;
                clr_msb = 1'b1;
                exp_ir = 8'h00;
                #1;
                check("rand_clr_now", saida_instrucao, model_out());
                step(1'b1, 1'($urandom_range(0, 1)), 8'($urandom));
                clr_msb = 1'b0;
            end
        end

        // Final anchor: load after random traffic.
        step(1'b1, 1'b1, 8'h3C);
        check("final_3c", saida_instrucao, 8'h3C);
        @(negedge clk);
        #1;
        chk_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
